// File: rtl/seq_mul_32bit.sv
// Sequential unsigned 32x32->64 shift-add multiplier. One multiplier bit per clock, reusing a single RCA_32bit.
// Optional build macro SEQ_MUL_ZERO_SKIP_EN: a zero operand at accept goes straight to DONE with P=0.

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module RCA_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic [32:0] c;

  assign c[0] = cin;

  // Bit i's carry-out is bit i+1's carry-in, which forms the ripple chain.
  fa_cell u_fa [31:0] (
    .a  (a),
    .b  (b),
    .ci (c[31:0]),
    .s  (s),
    .co (c[32:1])
  );

  assign cout = c[32];
endmodule

module seq_mul_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] P,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] mcand, hi, lo;
  logic [31:0] addend, sum;
  logic        carry;
  logic [5:0]  cnt;
  logic        accept, zero_op, last_iter;

  assign accept    = (state == IDLE) && start;
  assign last_iter = (state == RUN) && (cnt == 6'd31);

`ifdef SEQ_MUL_ZERO_SKIP_EN
  assign zero_op = (A == 32'd0) || (B == 32'd0);
`else
  assign zero_op = 1'b0;
`endif

  assign addend = lo[0] ? mcand : 32'd0;

  RCA_32bit u_rca (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .s    (sum),
    .cout (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = zero_op ? DONE : RUN;
      RUN:     if (cnt == 6'd31) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The adder carry becomes hi[31] after the shift, so the 64-bit accumulator cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      cnt   <= 6'd0;
    end else if (accept) begin
      mcand <= A;
      hi    <= 32'd0;
      lo    <= B;
      cnt   <= 6'd0;
    end else if (state == RUN) begin
      hi  <= {carry, sum[31:1]};
      lo  <= {sum[0], lo[31:1]};
      cnt <= cnt + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      P <= 64'd0;
    end else if (accept && zero_op) begin
      P <= 64'd0;
    end else if (last_iter) begin
      P <= {carry, sum, lo[31:1]};
    end
  end

  // Flags are registered from the next state, so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);
    end
  end
endmodule

// File: tb/tb_seq_mul_32bit.sv
// Directed and random checks of seq_mul_32bit against a plain A*B reference model.
module tb_seq_mul_32bit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [63:0] P;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  seq_mul_32bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_MUL_ZERO_SKIP_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Entered and left 1 time unit after a rising edge, with the DUT idle.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [63:0] want;
    want = {32'd0, a} * {32'd0, b};
    A = a; B = b; start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 1;
    while (!done && lat < 100) begin
      tick;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(a, b)));
    chk({tag, "_P"}, P, want);
    tick;
    chk({tag, "_idle"}, {62'd0, done, busy}, 64'd0);
    chk({tag, "_hold"}, P, want);
  endtask

  initial begin
    int ndone, first_done, gap, hold_bad, lat, active;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_P", P, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick;

    run_mul("m3x5", 32'd3, 32'd5);
    run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("max_const", P, 64'hFFFF_FFFE_0000_0001);
    run_mul("msb", 32'h8000_0000, 32'd2);
    chk("msb_const", P, 64'h0000_0001_0000_0000);

    // start pulsed mid-run must be dropped
    A = 32'd3; B = 32'd5; start = 1'b1;
    tick;
    start = 1'b0;
    ndone = 0; first_done = 0;
    for (int c = 1; c <= 80; c++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_done = c;
          chk("swb_P", P, 64'd15);
        end
      end
      if (c == 10) begin A = 32'd7; B = 32'd9; start = 1'b1; end
      else start = 1'b0;
      tick;
    end
    chk("swb_ndone", 64'(ndone), 64'd1);
    chk("swb_lat", 64'(first_done), 64'd33);
    chk("swb_busy", 64'(busy), 64'd0);
    chk("swb_hold", P, 64'd15);

    // async reset at iteration 16 aborts with no done
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (16) tick;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_P", P, 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    tick;
    rst_n = 1'b1;
    active = 0;
    repeat (40) begin
      tick;
      if (done || busy) active++;
    end
    chk("mrst_quiet", 64'(active), 64'd0);
    run_mul("after_rst", 32'd6, 32'd7);
    chk("after_rst_42", P, 64'd42);

    // start held high: second request accepted on the first IDLE cycle
    A = 32'd2; B = 32'd3; start = 1'b1;
    tick;
    A = 32'd4; B = 32'd5;
    lat = 1;
    while (!done && lat < 100) begin
      tick;
      lat++;
    end
    chk("b2b_lat", 64'(lat), 64'd33);
    chk("b2b_P1", P, 64'd6);
    gap = 0; hold_bad = 0;
    do begin
      tick;
      gap++;
      if (!done && P !== 64'd6) hold_bad++;
    end while (!done && gap < 100);
    chk("b2b_gap", 64'(gap), 64'd34);
    chk("b2b_hold", 64'(hold_bad), 64'd0);
    chk("b2b_P2", P, 64'd20);
    start = 1'b0;
    tick;
    tick;
    chk("b2b_idle", 64'(busy), 64'd0);

    run_mul("zeroA", 32'd0, 32'h1234);
    run_mul("zeroB", 32'hDEAD_BEEF, 32'd0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'd1;
      run_mul("rnd", ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
